issue_scoreboard: RTL and testbench

//  Sequences the issue stage: decides each cycle whether the decoded instruction may be

---
 rtl/issue_scoreboard.sv | 137 +++++++++++++
 tb/tb_issue_scoreboard.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// Issue-stage sequencer: gates decoded instructions on register hazards,
// outstanding LSU capacity and pending branches, and pulses issue_req_o
// the cycle after each accepted instruction.
module issue_scoreboard #(
   parameter int NUM_REGS    = 32,
   parameter int MAX_LSU_OUT = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                dec_valid_i,
   output logic                dec_ready_o,
   input  logic [4:0]          dec_rs1_i,
   input  logic                dec_rs1_used_i,
   input  logic [4:0]          dec_rs2_i,
   input  logic                dec_rs2_used_i,
   input  logic [4:0]          dec_rd_i,
   input  logic                dec_rd_we_i,
   input  logic                dec_is_lsu_i,
   input  logic                dec_is_branch_i,
   output logic                issue_req_o,
   input  logic                wb_valid_i,
   input  logic [4:0]          wb_addr_i,
   input  logic                lsu_done_i,
   input  logic                branch_resolved_i,
   input  logic                flush_i,
   output logic [NUM_REGS-1:0] busy_o,
   output logic [2:0]          lsu_out_o,
   output logic                err_o
);

   typedef enum logic {
      ST_RUN,
      ST_BR_WAIT
   } state_t;

   state_t              r_state;
   logic [NUM_REGS-1:0] r_busy;
   logic [2:0]          r_lsu_out;
   logic                r_issue;
   logic                r_err;

   logic                w_rs1_haz;
   logic                w_rs2_haz;
   logic                w_rd_haz;
   logic                w_lsu_full;
   logic                w_ready;
   logic                w_accept;
   logic [NUM_REGS-1:0] w_busy_set;
   logic [NUM_REGS-1:0] w_busy_clr;
   logic [NUM_REGS-1:0] w_busy_next;
   logic                w_wb_err;
   logic                w_lsu_inc;
   logic                w_lsu_dec;
   logic                w_lsu_err;
   logic [2:0]          w_lsu_next;

   // Hazard detection and ready, from registered state only (no writeback bypass)
   always_comb begin
      w_rs1_haz  = dec_rs1_used_i && r_busy[dec_rs1_i];
      w_rs2_haz  = dec_rs2_used_i && r_busy[dec_rs2_i];
      w_rd_haz   = dec_rd_we_i    && r_busy[dec_rd_i];
      w_lsu_full = dec_is_lsu_i   && (r_lsu_out == 3'(MAX_LSU_OUT));
      w_ready    = !rst_i && (r_state == ST_RUN) && !flush_i &&
                   !w_rs1_haz && !w_rs2_haz && !w_rd_haz && !w_lsu_full;
      w_accept   = dec_valid_i && w_ready;
   end

   // Scoreboard next value: writeback clears, accepted destination sets (set wins)
   always_comb begin
      w_busy_set = '0;
      w_busy_clr = '0;
      w_wb_err   = 1'b0;
      if (w_accept && dec_rd_we_i && (dec_rd_i != 5'd0)) begin
         w_busy_set[dec_rd_i] = 1'b1;
      end
      if (wb_valid_i && (wb_addr_i != 5'd0)) begin
         if (r_busy[wb_addr_i]) begin
            w_busy_clr[wb_addr_i] = 1'b1;
         end else begin
            w_wb_err = 1'b1;
         end
      end
      w_busy_next    = (r_busy & ~w_busy_clr) | w_busy_set;
      w_busy_next[0] = 1'b0;
   end

   // Outstanding LSU counter next value; simultaneous inc and dec cancel
   always_comb begin
      w_lsu_inc  = w_accept && dec_is_lsu_i;
      w_lsu_dec  = lsu_done_i && (r_lsu_out != 3'd0);
      w_lsu_err  = lsu_done_i && (r_lsu_out == 3'd0);
      w_lsu_next = r_lsu_out;
      case ({w_lsu_inc, w_lsu_dec})
         2'b10:   w_lsu_next = r_lsu_out + 3'd1;
         2'b01:   w_lsu_next = r_lsu_out - 3'd1;
         default: w_lsu_next = r_lsu_out;
      endcase
   end

   // Control FSM with registered issue pulse, scoreboard, counter and sticky error
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= ST_RUN;
         r_busy    <= '0;
         r_lsu_out <= '0;
         r_issue   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_busy    <= w_busy_next;
         r_lsu_out <= w_lsu_next;
         r_issue   <= w_accept;
         if (w_wb_err || w_lsu_err) begin
            r_err <= 1'b1;
         end
         case (r_state)
            ST_RUN: begin
               if (w_accept && dec_is_branch_i) begin
                  r_state <= ST_BR_WAIT;
               end
            end
            ST_BR_WAIT: begin
               if (branch_resolved_i || flush_i) begin
                  r_state <= ST_RUN;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign dec_ready_o = w_ready;
   assign issue_req_o = r_issue;
   assign busy_o      = r_busy;
   assign lsu_out_o   = r_lsu_out;
   assign err_o       = r_err;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed sequences with hand-computed results.
// Each expected accept pushes the cycle its issue pulse must appear in; a
// negedge monitor pops and compares whenever issue_req_o is high.
module tb_issue_scoreboard;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        dec_valid_i;
   logic        dec_ready_o;
   logic [4:0]  dec_rs1_i;
   logic        dec_rs1_used_i;
   logic [4:0]  dec_rs2_i;
   logic        dec_rs2_used_i;
   logic [4:0]  dec_rd_i;
   logic        dec_rd_we_i;
   logic        dec_is_lsu_i;
   logic        dec_is_branch_i;
   logic        issue_req_o;
   logic        wb_valid_i;
   logic [4:0]  wb_addr_i;
   logic        lsu_done_i;
   logic        branch_resolved_i;
   logic        flush_i;
   logic [31:0] busy_o;
   logic [2:0]  lsu_out_o;
   logic        err_o;

   int unsigned cyc = 0;
   int unsigned n_total = 0;
   int unsigned n_pass = 0;
   int unsigned q_issue[$];

   issue_scoreboard #(.NUM_REGS(32), .MAX_LSU_OUT(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
      .dec_rs1_i(dec_rs1_i), .dec_rs1_used_i(dec_rs1_used_i),
      .dec_rs2_i(dec_rs2_i), .dec_rs2_used_i(dec_rs2_used_i),
      .dec_rd_i(dec_rd_i), .dec_rd_we_i(dec_rd_we_i),
      .dec_is_lsu_i(dec_is_lsu_i), .dec_is_branch_i(dec_is_branch_i),
      .issue_req_o(issue_req_o),
      .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i),
      .lsu_done_i(lsu_done_i), .branch_resolved_i(branch_resolved_i),
      .flush_i(flush_i),
      .busy_o(busy_o), .lsu_out_o(lsu_out_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every issue pulse must match the next expected cycle
   always @(negedge clk_i) begin
      if (issue_req_o === 1'b1) begin
         if (q_issue.size() == 0) begin
            chk("issue_unexpected", cyc, 32'hFFFF_FFFF);
         end else begin
            chk("issue_cycle", cyc, q_issue.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic present(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic we,
                          input logic lsu, input logic br);
      dec_valid_i     = 1'b1;
      dec_rs1_i       = rs1;
      dec_rs1_used_i  = u1;
      dec_rs2_i       = rs2;
      dec_rs2_used_i  = u2;
      dec_rd_i        = rd;
      dec_rd_we_i     = we;
      dec_is_lsu_i    = lsu;
      dec_is_branch_i = br;
      #1;
   endtask

   task automatic idle();
      dec_valid_i     = 1'b0;
      dec_rs1_used_i  = 1'b0;
      dec_rs2_used_i  = 1'b0;
      dec_rd_we_i     = 1'b0;
      dec_is_lsu_i    = 1'b0;
      dec_is_branch_i = 1'b0;
   endtask

   // Expect acceptance at the coming edge: ready now, pulse in the next cycle
   task automatic accept(input string name);
      chk(name, {31'd0, dec_ready_o}, 32'd1);
      q_issue.push_back(cyc + 1);
      tick();
   endtask

   task automatic wb(input logic [4:0] a);
      wb_valid_i = 1'b1;
      wb_addr_i  = a;
      tick();
      wb_valid_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1;
      idle();
      dec_rs1_i = '0; dec_rs2_i = '0; dec_rd_i = '0;
      wb_valid_i = 1'b0; wb_addr_i = '0; lsu_done_i = 1'b0;
      branch_resolved_i = 1'b0; flush_i = 1'b0;

      // Reset state; ready held low during reset even with a clean instruction
      tick();
      present(5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
      chk("rst_ready", {31'd0, dec_ready_o}, 32'd0);
      chk("rst_busy", busy_o, 32'd0);
      chk("rst_lsu", {29'd0, lsu_out_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      tick();
      rst_i = 1'b0;
      idle();
      tick();

      // 1: addi x5
      present(5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
      accept("t1_ready");
      idle();
      chk("t1_busy", busy_o, 32'h20);

      // 2: add x6,x5,x1 stalls on x5; wb at k unblocks at k+1
      present(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
      chk("t2_raw_stall", {31'd0, dec_ready_o}, 32'd0);
      tick();
      chk("t2_raw_stall2", {31'd0, dec_ready_o}, 32'd0);
      wb_valid_i = 1'b1; wb_addr_i = 5'd5;
      #1;
      chk("t2_no_bypass", {31'd0, dec_ready_o}, 32'd0);
      tick();
      wb_valid_i = 1'b0;
      #1;
      accept("t2_ready_after_wb");
      idle();
      chk("t2_busy", busy_o, 32'h40);
      wb(5'd6);
      chk("t2_busy_clean", busy_o, 32'd0);

      // 3: loads to x10..x13 against MAX_LSU_OUT=2
      present(5'd2, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
      accept("t3_ld1");
      present(5'd2, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);
      accept("t3_ld2");
      chk("t3_lsu2", {29'd0, lsu_out_o}, 32'd2);
      present(5'd2, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
      chk("t3_ld3_stall", {31'd0, dec_ready_o}, 32'd0);
      lsu_done_i = 1'b1;
      #1;
      chk("t3_done_no_bypass", {31'd0, dec_ready_o}, 32'd0);
      tick();
      lsu_done_i = 1'b0;
      chk("t3_lsu_after_done", {29'd0, lsu_out_o}, 32'd1);
      #1;
      accept("t3_ld3");
      chk("t3_lsu_full", {29'd0, lsu_out_o}, 32'd2);
      idle();
      lsu_done_i = 1'b1;
      tick();
      lsu_done_i = 1'b0;
      present(5'd2, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1, 1'b0);
      lsu_done_i = 1'b1;
      #1;
      accept("t3_ld4_with_done");
      lsu_done_i = 1'b0;
      idle();
      chk("t3_inc_dec_cancel", {29'd0, lsu_out_o}, 32'd1);
      chk("t3_busy", busy_o, 32'h3C00);
      lsu_done_i = 1'b1;
      tick();
      lsu_done_i = 1'b0;
      chk("t3_lsu_zero", {29'd0, lsu_out_o}, 32'd0);
      wb(5'd10); wb(5'd11); wb(5'd12); wb(5'd13);
      chk("t3_busy_clean", busy_o, 32'd0);
      chk("t3_err_clean", {31'd0, err_o}, 32'd0);

      // 4: branch wait, resolved leaves; then flush also leaves
      present(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
      accept("t4_branch");
      present(5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("t4_br_wait", {31'd0, dec_ready_o}, 32'd0);
         tick();
      end
      branch_resolved_i = 1'b1;
      #1;
      chk("t4_resolve_same_cycle", {31'd0, dec_ready_o}, 32'd0);
      tick();
      branch_resolved_i = 1'b0;
      #1;
      accept("t4_after_resolve");
      idle();
      chk("t4_busy", busy_o, 32'h80);
      wb(5'd7);
      present(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      accept("t4_branch2");
      present(5'd0, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
      flush_i = 1'b1;
      #1;
      chk("t4_flush_ready", {31'd0, dec_ready_o}, 32'd0);
      tick();
      flush_i = 1'b0;
      #1;
      accept("t4_after_flush");
      idle();
      wb(5'd8);
      branch_resolved_i = 1'b1;
      tick();
      branch_resolved_i = 1'b0;
      chk("t4_resolve_in_run_err", {31'd0, err_o}, 32'd0);
      chk("t4_busy_clean", busy_o, 32'd0);

      // 5: protocol errors, sticky
      wb(5'd0);
      chk("t5_wb_x0_no_err", {31'd0, err_o}, 32'd0);
      wb(5'd7);
      chk("t5_err_set", {31'd0, err_o}, 32'd1);
      tick(); tick();
      chk("t5_err_sticky", {31'd0, err_o}, 32'd1);
      lsu_done_i = 1'b1;
      tick();
      lsu_done_i = 1'b0;
      chk("t5_lsu_stays_0", {29'd0, lsu_out_o}, 32'd0);

      // 6: set beats clear on x9; then async reset mid-stall
      present(5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
      wb_valid_i = 1'b1; wb_addr_i = 5'd9;
      #1;
      accept("t6_set_wins_accept");
      wb_valid_i = 1'b0;
      chk("t6_busy9", busy_o, 32'h200);
      chk("t6_lsu1", {29'd0, lsu_out_o}, 32'd1);
      present(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
      chk("t6_waw_stall", {31'd0, dec_ready_o}, 32'd0);
      tick();
      #1;
      rst_i = 1'b1;
      #1;
      chk("t6_rst_busy", busy_o, 32'd0);
      chk("t6_rst_lsu", {29'd0, lsu_out_o}, 32'd0);
      chk("t6_rst_err", {31'd0, err_o}, 32'd0);
      chk("t6_rst_issue", {31'd0, issue_req_o}, 32'd0);
      chk("t6_rst_ready", {31'd0, dec_ready_o}, 32'd0);
      tick();
      idle();
      rst_i = 1'b0;
      tick(); tick();

      chk("issue_queue_drained", q_issue.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
